// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    // Writeback source identity, also used as the round-robin pointer value.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    // Relative age of the two slot entries.
    // AGE_TIE means both entries were loaded at the same edge.
    typedef enum logic [1:0] {
        AGE_TIE   = 2'd0,
        AGE_A_OLD = 2'd1,
        AGE_B_OLD = 2'd2
    } age_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two writeback sources, the arbiter and the register file.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int NREG   = regfile_pkg::NREG
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              rf_regen;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [NREG-1:0]   busy;

    // Driving side: the writeback sources, observing the register-file port.
    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  rf_regen, rf_wa, rf_wd, busy
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output rf_regen, rf_wa, rf_wd, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry valid/ready holding register for a single writeback source.
// Writes to the read-only register 0 are accepted and discarded.
module wb_slot
    import regfile_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    output logic    in_ready,
    input  wb_req_t in_req,
    input  logic    grant,
    output logic    full,
    output logic    load,
    output wb_req_t req
);

    logic    full_reg, full_next;
    wb_req_t req_reg,  req_next;

    // Space is available if empty, or if the current entry leaves this edge.
    assign in_ready = ~full_reg | grant;
    // Only real register writes occupy the slot.
    assign load     = in_valid & in_ready & (in_req.addr != ZERO_REG);
    assign full     = full_reg;
    assign req      = req_reg;

    // Next slot contents: drain on grant, refill on load (refill wins).
    always_comb begin
        full_next = full_reg;
        req_next  = req_reg;
        if (grant) begin
            full_next = 1'b0;
        end
        if (load) begin
            full_next = 1'b1;
            req_next  = in_req;
        end
    end

    // Slot state register; reset drops anything captured in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg <= 1'b0;
            req_reg  <= '0;
        end else begin
            full_reg <= full_next;
            req_reg  <= req_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU result
// path (A) and the load path (B). Oldest entry wins; entries loaded at the
// same edge are resolved by a round-robin pointer. Port outputs are registered
// and a busy vector flags registers with a write still in flight.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    logic    a_full, b_full;
    logic    a_load, b_load;
    logic    a_grant, b_grant;
    logic    a_ready, b_ready;
    wb_req_t a_req, b_req;
    wb_req_t a_in, b_in;

    age_e    age_reg, age_next;
    src_e    rr_reg,  rr_next;

    logic              rf_regen_reg, rf_regen_next;
    logic [ADDR_W-1:0] rf_wa_reg,    rf_wa_next;
    logic [DATA_W-1:0] rf_wd_reg,    rf_wd_next;
    logic [NREG-1:0]   busy_vec;

    assign a_in = '{addr: bus.a_addr, data: bus.a_data};
    assign b_in = '{addr: bus.b_addr, data: bus.b_data};

    wb_slot u_slot_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.a_valid),
        .in_ready (a_ready),
        .in_req   (a_in),
        .grant    (a_grant),
        .full     (a_full),
        .load     (a_load),
        .req      (a_req)
    );

    wb_slot u_slot_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.b_valid),
        .in_ready (b_ready),
        .in_req   (b_in),
        .grant    (b_grant),
        .full     (b_full),
        .load     (b_load),
        .req      (b_req)
    );

    // Grant selection from slot state only: single full slot wins outright,
    // otherwise the older entry, otherwise the rr pointer (which then flips).
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        rr_next = rr_reg;
        if (a_full && b_full) begin
            case (age_reg)
                AGE_A_OLD: a_grant = 1'b1;
                AGE_B_OLD: b_grant = 1'b1;
                default: begin
                    if (rr_reg == SRC_A) begin
                        a_grant = 1'b1;
                        rr_next = SRC_B;
                    end else begin
                        b_grant = 1'b1;
                        rr_next = SRC_A;
                    end
                end
            endcase
        end else begin
            a_grant = a_full;
            b_grant = b_full;
        end
    end

    // Age tracking: a slot loaded this edge is younger than one that was not.
    // When neither loads, any surviving pair keeps its existing order.
    always_comb begin
        age_next = age_reg;
        if (a_load && b_load) begin
            age_next = AGE_TIE;
        end else if (a_load) begin
            age_next = AGE_B_OLD;
        end else if (b_load) begin
            age_next = AGE_A_OLD;
        end
    end

    // Write-port next values; address and data hold when nothing is granted.
    always_comb begin
        rf_regen_next = a_grant | b_grant;
        rf_wa_next    = rf_wa_reg;
        rf_wd_next    = rf_wd_reg;
        if (a_grant) begin
            rf_wa_next = a_req.addr;
            rf_wd_next = a_req.data;
        end else if (b_grant) begin
            rf_wa_next = b_req.addr;
            rf_wd_next = b_req.data;
        end
    end

    // Arbitration state and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_reg      <= AGE_TIE;
            rr_reg       <= SRC_A;
            rf_regen_reg <= 1'b0;
            rf_wa_reg    <= '0;
            rf_wd_reg    <= '0;
        end else begin
            age_reg      <= age_next;
            rr_reg       <= rr_next;
            rf_regen_reg <= rf_regen_next;
            rf_wa_reg    <= rf_wa_next;
            rf_wd_reg    <= rf_wd_next;
        end
    end

    // Busy decode: a register is busy while its write sits in either slot or
    // in the output stage.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            assign busy_vec[gi] = (a_full       && (a_req.addr == ADDR_W'(gi)))
                               || (b_full       && (b_req.addr == ADDR_W'(gi)))
                               || (rf_regen_reg && (rf_wa_reg  == ADDR_W'(gi)));
        end
    endgenerate

    assign bus.a_ready  = a_ready;
    assign bus.b_ready  = b_ready;
    assign bus.rf_regen = rf_regen_reg;
    assign bus.rf_wa    = rf_wa_reg;
    assign bus.rf_wd    = rf_wd_reg;
    assign bus.busy     = busy_vec;

endmodule
